mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
Multicycle MIPS control unit. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables. It also contains the ALU decoder that produces the 3-bit op for the datapath ALU. It sits directly upstream of the ALU and consumes the ALU zero flag to resolve branches.

Parameters:
None (opcode, funct and ALU op encodings are fixed; listed under Behaviour).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag (1 when ALU y == 0)
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  data memory write enable
irwrite  out  1  instruction register load enable
regdst  out  1  write register select: 0=rt, 1=rd
memtoreg  out  1  writeback select: 0=ALUOut, 1=MemData
regwrite  out  1  register file write enable
alusrca  out  1  ALU a select: 0=PC, 1=rs
alusrcb  out  2  ALU b select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pcsrc  out  2  next-PC select: 00=ALU y, 01=ALUOut, 10=jump target
pcen  out  1  PC load enable
alucontrol  out  3  ALU op
instr_done  out  1  high in the last cycle of every instruction
illegal_op  out  1  high in DECODE when op is unsupported

Behaviour:
- Reset: async, active-high. state <= FETCH immediately. While reset=1, irwrite, pcen, regwrite and memwrite are forced 0, as are instr_done and illegal_op. All other outputs follow the FETCH decode.
- State register updates on the rising edge of clk. All outputs are Moore-decoded from state, except two:
  - pcen = pcwrite | (branch & zero)
  - alucontrol depends on aluop and funct.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00, pcsrc=00, iord=0.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1, regdst=0, instr_done=1.
  - MEMWR: iord=1, memwrite=1, instr_done=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1, instr_done=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1.
  - JUMP: pcsrc=10, pcwrite=1, instr_done=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other op -> FETCH, with illegal_op=1 and instr_done=1 in that DECODE cycle
  - MEMADR->MEMRD if op=lw, else MEMWR.
  - MEMRD->MEMWB.
  - EXECUTE->ALUWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - op is sampled only in DECODE and MEMADR; it is stable because irwrite=0 outside FETCH.
- ALU decoder:
  - aluop=00 -> 010 (add).
  - aluop=01 -> 110 (sub).
  - aluop=10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other funct -> 010.
  - aluop=11 is unused -> 010.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- zero is sampled only in BRANCH. pcen is combinational on zero within that cycle.
- Reset asserted mid-instruction aborts the instruction; no write enable is asserted after reset rises. The first cycle after reset falls is FETCH with irwrite=1 and pcen=1.
- No latches: every output is assigned in every state, and the state encoding has a default branch to FETCH.

Test Plan:
- Reset held 3 cycles, then released -> during reset irwrite=pcen=regwrite=memwrite=0; first cycle after release is FETCH with irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op=100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. In MEMRD iord=1; in MEMWB regwrite=1, memtoreg=1, regdst=0, instr_done=1; 5 cycles total.
- R-type with funct 101010, 100010, 100100, 100101, 100000 -> in EXECUTE alucontrol = 111, 110, 000, 001, 010 respectively; in ALUWB regwrite=1, regdst=1.
- beq (op=000100) run twice -> with zero=1 in BRANCH, pcen=1 and pcsrc=01; with zero=0, pcen=0; alucontrol=110 in both runs; next state is FETCH in both.
- sw, addi, j back-to-back -> sw: memwrite=1 only in MEMWR (4 cycles). addi: ADDIEX has alusrcb=10; ADDIWB has regwrite=1, regdst=0. j: JUMP has pcsrc=10, pcen=1 (3 cycles).
- Unsupported op (111111), then reset asserted during MEMRD of an lw -> DECODE shows illegal_op=1, next state FETCH. On reset, state is FETCH immediately and MEMWB/regwrite never occurs.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller uses the master modport; the datapath (or a bench) uses slave.
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal_op
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal_op
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, plus the ALU decoder feeding the datapath ALU.
module mips_mc_controller (
  input  logic                   clk,
  input  logic                   reset,
  mips_mc_controller_if.master   bus
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXECUTE = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state;
  logic [3:0] next_state;

  // Raw Moore decode, before reset gating of the write enables.
  logic       iord_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] pcsrc_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic [1:0] aluop_s;
  logic       done_s;
  logic       illegal_s;
  logic       op_legal;
  logic [2:0] alucontrol_s;

  always_comb begin
    unique case (bus.op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = MEMWB;
      EXECUTE: next_state = ALUWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no state can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    iord_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    pcsrc_s    = 2'b00;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    aluop_s    = ALUOP_ADD;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    case (state)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrcb_s = 2'b01;
      end
      DECODE: begin
        alusrcb_s = 2'b11;
        illegal_s = ~op_legal;
        done_s    = ~op_legal;
      end
      MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      MEMRD:  iord_s = 1'b1;
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      EXECUTE: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      BRANCH: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        pcsrc_s   = 2'b01;
        branch_s  = 1'b1;
        done_s    = 1'b1;
      end
      ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      JUMP: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
        done_s    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol_s = ALU_ADD;
    case (aluop_s)
      ALUOP_SUB: alucontrol_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (bus.funct)
          FN_ADD:  alucontrol_s = ALU_ADD;
          FN_SUB:  alucontrol_s = ALU_SUB;
          FN_AND:  alucontrol_s = ALU_AND;
          FN_OR:   alucontrol_s = ALU_OR;
          FN_SLT:  alucontrol_s = ALU_SLT;
          default: alucontrol_s = ALU_ADD;
        endcase
      end
      default: alucontrol_s = ALU_ADD;
    endcase
  end

  // Enables are masked while reset is high so an aborted instruction can
  // never write anything, even in the cycle reset rises.
  assign bus.iord       = iord_s;
  assign bus.memwrite   = memwrite_s & ~reset;
  assign bus.irwrite    = irwrite_s  & ~reset;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.regwrite   = regwrite_s & ~reset;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.pcen       = (pcwrite_s | (branch_s & bus.zero)) & ~reset;
  assign bus.alucontrol = alucontrol_s;
  assign bus.instr_done = done_s    & ~reset;
  assign bus.illegal_op = illegal_s & ~reset;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized self-checking bench: each instruction is expanded by a
// cycle-by-cycle expectation model and compared against every DUT output.
module tb_mips_mc_controller;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t c;
    c.iord       = bus.iord;
    c.memwrite   = bus.memwrite;
    c.irwrite    = bus.irwrite;
    c.regdst     = bus.regdst;
    c.memtoreg   = bus.memtoreg;
    c.regwrite   = bus.regwrite;
    c.alusrca    = bus.alusrca;
    c.alusrcb    = bus.alusrcb;
    c.pcsrc      = bus.pcsrc;
    c.pcen       = bus.pcen;
    c.alucontrol = bus.alucontrol;
    c.instr_done = bus.instr_done;
    c.illegal_op = bus.illegal_op;
    return c;
  endfunction

  function automatic int cycles_of(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] funct);
    case (funct)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle idx of an instruction (idx 0 = fetch).
  function automatic ctl_t expect_cycle(input logic [5:0] op, input logic [5:0] funct,
                                        input logic zero, input int idx);
    ctl_t e = '0;
    e.alucontrol = 3'b010;
    if (idx == 0) begin
      e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01;
    end else if (idx == 1) begin
      e.alusrcb = 2'b11;
      if (cycles_of(op) == 2) begin
        e.illegal_op = 1'b1; e.instr_done = 1'b1;
      end
    end else begin
      case (op)
        6'b100011, 6'b101011: begin
          if (idx == 2) begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
          end else if (op == 6'b100011 && idx == 3) begin
            e.iord = 1'b1;
          end else if (op == 6'b100011) begin
            e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
          end else begin
            e.iord = 1'b1; e.memwrite = 1'b1; e.instr_done = 1'b1;
          end
        end
        6'b000000: begin
          if (idx == 2) begin
            e.alusrca = 1'b1; e.alucontrol = rtype_alu(funct);
          end else begin
            e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
          end
        end
        6'b000100: begin
          e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
          e.pcen = zero; e.instr_done = 1'b1;
        end
        6'b001000: begin
          if (idx == 2) begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
          end else begin
            e.regwrite = 1'b1; e.instr_done = 1'b1;
          end
        end
        default: begin
          e.pcsrc = 2'b10; e.pcen = 1'b1; e.instr_done = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  function automatic ctl_t reset_expect();
    ctl_t e = '0;
    e.alusrcb    = 2'b01;
    e.alucontrol = 3'b010;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // zsel: 0/1 forces zero, 2 randomizes it each cycle.
  // Caller must be 1 time unit after the edge that starts the FETCH cycle.
  // stop_at < 0 runs the whole instruction; otherwise stops after that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                           input int zsel, input int stop_at);
    int n = cycles_of(op);
    if (stop_at >= 0 && stop_at < n) n = stop_at + 1;
    bus.op    = op;
    bus.funct = funct;
    for (int idx = 0; idx < n; idx++) begin
      if (idx > 0) next_cycle();
      bus.zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      check($sformatf("op%b_fn%b_z%0d_c%0d", op, funct, bus.zero, idx),
            32'(observe()), 32'(expect_cycle(op, funct, bus.zero, idx)));
    end
  endtask

  logic [5:0] legal_ops [6];
  logic [5:0] good_fn   [5];

  initial begin
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    good_fn   = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b100000};
    bus.op    = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;

    // Reset held for three cycles with random instruction bits present.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.op = 6'($urandom); bus.zero = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("in_reset_c%0d", i), 32'(observe()), 32'(reset_expect()));
    end
    next_cycle();
    reset = 1'b0;

    run_instr(6'b100011, 6'b000000, 2, -1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      run_instr(6'b000000, good_fn[i], 2, -1);
    end
    next_cycle(); run_instr(6'b000100, 6'b000000, 1, -1);
    next_cycle(); run_instr(6'b000100, 6'b000000, 0, -1);
    next_cycle(); run_instr(6'b101011, 6'b000000, 2, -1);
    next_cycle(); run_instr(6'b001000, 6'b000000, 2, -1);
    next_cycle(); run_instr(6'b000010, 6'b000000, 2, -1);
    next_cycle(); run_instr(6'b111111, 6'b000000, 2, -1);

    // lw aborted in MEMRD: reset rises mid-cycle and holds for two edges.
    next_cycle(); run_instr(6'b100011, 6'b000000, 2, 3);
    reset = 1'b1;
    #1;
    check("abort_lw_memrd", 32'(observe()), 32'(reset_expect()));
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      check($sformatf("abort_hold_c%0d", i), 32'(observe()), 32'(reset_expect()));
    end
    next_cycle();
    reset = 1'b0;

    // Random instruction stream, including unsupported opcodes and functs.
    for (int k = 0; k < 300; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : good_fn[$urandom_range(0, 4)];
      if (k > 0) next_cycle();
      run_instr(op, fn, 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
